// File: rtl/vx_gpr_read_unit_if.sv
// Read-request, response and write-back bundle of the GPR read unit.
interface vx_gpr_read_unit_if #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 4
);
    localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

    logic                         req_valid;
    logic                         req_ready;
    logic [WID_W-1:0]             req_wid;
    logic [4:0]                   req_rs1;
    logic [4:0]                   req_rs2;
    logic [4:0]                   req_rs3;
    logic                         req_use_rs3;

    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [NUM_THREADS-1:0][31:0] rs1_data;
    logic [NUM_THREADS-1:0][31:0] rs2_data;
    logic [NUM_THREADS-1:0][31:0] rs3_data;

    logic                         wb_valid;
    logic [WID_W-1:0]             wb_wid;
    logic [4:0]                   wb_rd;
    logic [NUM_THREADS-1:0]       wb_tmask;
    logic [NUM_THREADS-1:0][31:0] wb_data;

    modport master (
        output req_valid, req_wid, req_rs1, req_rs2, req_rs3, req_use_rs3,
        input  req_ready,
        input  rsp_valid, rs1_data, rs2_data, rs3_data,
        output rsp_ready,
        output wb_valid, wb_wid, wb_rd, wb_tmask, wb_data
    );

    modport slave (
        input  req_valid, req_wid, req_rs1, req_rs2, req_rs3, req_use_rs3,
        output req_ready,
        output rsp_valid, rs1_data, rs2_data, rs3_data,
        input  rsp_ready,
        input  wb_valid, wb_wid, wb_rd, wb_tmask, wb_data
    );
endinterface

// File: rtl/vx_gpr_read_unit.sv
// Per-warp GPR file with two read ports and one masked write port; rs3 takes
// a second cycle on read port 0 so the bank stays 2R1W.
module vx_gpr_lane #(
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr0_i,
    input  logic [AW-1:0] raddr1_i,
    output logic [31:0]   rdata0_o,
    output logic [31:0]   rdata1_o
);
    localparam int DEPTH = 1 << AW;

    logic [DEPTH-1:0][31:0] mem_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Reads see pre-edge contents: a same-cycle write is not forwarded.
    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];
endmodule

module vx_gpr_read_unit #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 4
) (
    input  logic              clk,
    input  logic              reset,
    vx_gpr_read_unit_if.slave bus
);
    localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int AW    = WID_W + 5;

    typedef enum logic {IDLE, READ_RS3} state_e;

    state_e                       state_q, state_d;
    logic                         rsp_valid_q, rsp_valid_d;
    logic [NUM_THREADS-1:0][31:0] rs1_q, rs1_d;
    logic [NUM_THREADS-1:0][31:0] rs2_q, rs2_d;
    logic [NUM_THREADS-1:0][31:0] rs3_q, rs3_d;
    logic [WID_W-1:0]             wid_q, wid_d;
    logic [4:0]                   rs3_idx_q, rs3_idx_d;

    logic                         req_ready;
    logic                         accept;
    logic                         wen;
    logic [AW-1:0]                raddr0, raddr1, waddr;
    logic [NUM_THREADS-1:0][31:0] rd0, rd1;

    assign req_ready = (state_q == IDLE) && (!rsp_valid_q || bus.rsp_ready);
    assign accept    = bus.req_valid && req_ready;

    // Port 0 is borrowed for rs3 while the FSM sits in READ_RS3.
    assign raddr0 = (state_q == READ_RS3) ? {wid_q, rs3_idx_q} : {bus.req_wid, bus.req_rs1};
    assign raddr1 = {bus.req_wid, bus.req_rs2};
    assign waddr  = {bus.wb_wid, bus.wb_rd};
    assign wen    = bus.wb_valid && (bus.wb_rd != 5'd0);

    for (genvar i = 0; i < NUM_THREADS; i++) begin : g_lane
        vx_gpr_lane #(.AW(AW)) u_lane (
            .clk      (clk),
            .reset    (reset),
            .we_i     (wen && bus.wb_tmask[i]),
            .waddr_i  (waddr),
            .wdata_i  (bus.wb_data[i]),
            .raddr0_i (raddr0),
            .raddr1_i (raddr1),
            .rdata0_o (rd0[i]),
            .rdata1_o (rd1[i])
        );
    end

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rsp_valid_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rs3_d       = rs3_q;
        wid_d       = wid_q;
        rs3_idx_d   = rs3_idx_q;
        if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (accept) begin
                    rs1_d     = rd0;
                    rs2_d     = rd1;
                    wid_d     = bus.req_wid;
                    rs3_idx_d = bus.req_rs3;
                    if (bus.req_use_rs3) begin
                        state_d = READ_RS3;
                    end else begin
                        rs3_d       = '0;
                        rsp_valid_d = 1'b1;
                    end
                end
            end
            READ_RS3: begin
                rs3_d       = rd0;
                rsp_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rs3_q       <= '0;
            wid_q       <= '0;
            rs3_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rs3_q       <= rs3_d;
            wid_q       <= wid_d;
            rs3_idx_q   <= rs3_idx_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rs1_data  = rs1_q;
    assign bus.rs2_data  = rs2_q;
    assign bus.rs3_data  = rs3_q;
endmodule

// File: tb/tb_vx_gpr_read_unit.sv
// Bench for vx_gpr_read_unit: directed table, corner sequences, and random
// traffic checked against an array/queue reference model.
module tb_vx_gpr_read_unit;
    localparam int NW = 4;
    localparam int NT = 4;

    typedef logic [NT-1:0][31:0] vec_t;
    typedef struct {
        vec_t r1;
        vec_t r2;
        vec_t r3;
    } rsp_t;
    typedef struct {
        logic [1:0] wid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rs3;
        logic       use3;
        vec_t       e1;
        vec_t       e2;
        vec_t       e3;
        int         lat;
    } tv_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_err = 0;

    vx_gpr_read_unit_if #(.NUM_WARPS(NW), .NUM_THREADS(NT)) bus ();

    vx_gpr_read_unit #(.NUM_WARPS(NW), .NUM_THREADS(NT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t fill(input logic [31:0] base, input logic [31:0] inc);
        vec_t v;
        for (int l = 0; l < NT; l++) v[l] = base + inc * l;
        return v;
    endfunction

    // ---------------- reference model ----------------
    logic [31:0] m_gpr [NW][32][NT];
    rsp_t        exp_q[$];
    logic        pend, hold;
    logic [1:0]  pend_wid;
    logic [4:0]  pend_rs3;
    rsp_t        pend_rsp, held;

    function automatic vec_t mread(input logic [1:0] w, input logic [4:0] r);
        vec_t v;
        for (int l = 0; l < NT; l++) v[l] = m_gpr[w][r][l];
        return v;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NW; w++)
                for (int r = 0; r < 32; r++)
                    for (int l = 0; l < NT; l++) m_gpr[w][r][l] = '0;
            exp_q.delete();
            pend = 1'b0;
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", bus.rsp_valid, 1'b1);
                chk("hold_rs1", bus.rs1_data, held.r1);
                chk("hold_rs2", bus.rs2_data, held.r2);
                chk("hold_rs3", bus.rs3_data, held.r3);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_rsp: got a response, expected none");
                end else begin
                    rsp_t e;
                    e = exp_q.pop_front();
                    chk("model_rs1", bus.rs1_data, e.r1);
                    chk("model_rs2", bus.rs2_data, e.r2);
                    chk("model_rs3", bus.rs3_data, e.r3);
                end
            end
            hold = bus.rsp_valid && !bus.rsp_ready;
            held.r1 = bus.rs1_data;
            held.r2 = bus.rs2_data;
            held.r3 = bus.rs3_data;
            // rs3 is sampled one cycle after accept, so it sees the accept-edge write.
            if (pend) begin
                chk("model_busy_ready", bus.req_ready, 1'b0);
                pend_rsp.r3 = mread(pend_wid, pend_rs3);
                exp_q.push_back(pend_rsp);
                pend = 1'b0;
            end
            if (bus.req_valid && bus.req_ready) begin
                pend_rsp.r1 = mread(bus.req_wid, bus.req_rs1);
                pend_rsp.r2 = mread(bus.req_wid, bus.req_rs2);
                if (bus.req_use_rs3) begin
                    pend     = 1'b1;
                    pend_wid = bus.req_wid;
                    pend_rs3 = bus.req_rs3;
                end else begin
                    pend_rsp.r3 = '0;
                    exp_q.push_back(pend_rsp);
                end
            end
            if (bus.wb_valid && bus.wb_rd != 5'd0)
                for (int l = 0; l < NT; l++)
                    if (bus.wb_tmask[l]) m_gpr[bus.wb_wid][bus.wb_rd][l] = bus.wb_data[l];
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr(input logic [1:0] w, input logic [4:0] rd, input logic [NT-1:0] m, input vec_t d);
        bus.wb_valid = 1'b1;
        bus.wb_wid   = w;
        bus.wb_rd    = rd;
        bus.wb_tmask = m;
        bus.wb_data  = d;
        @(posedge clk); #1;
        bus.wb_valid = 1'b0;
    endtask

    // Returns #1 after the accepting edge.
    task automatic send(input logic [1:0] w, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] r3, input logic u);
        int n;
        bus.req_valid   = 1'b1;
        bus.req_wid     = w;
        bus.req_rs1     = r1;
        bus.req_rs2     = r2;
        bus.req_rs3     = r3;
        bus.req_use_rs3 = u;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_timeout", (n < 20), 1'b1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!bus.rsp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    function automatic tv_t mk(input logic [1:0] w, input logic [4:0] r1, input logic [4:0] r2,
                               input logic [4:0] r3, input logic u, input vec_t e1,
                               input vec_t e2, input vec_t e3, input int lat);
        tv_t t;
        t.wid = w; t.rs1 = r1; t.rs2 = r2; t.rs3 = r3; t.use3 = u;
        t.e1 = e1; t.e2 = e2; t.e3 = e3; t.lat = lat;
        return t;
    endfunction

    tv_t  tv[6];
    vec_t aa_exp, v11, v22, v33, v31, v55;
    int   lat;

    initial begin
        bus.req_valid = 1'b0; bus.req_wid = '0; bus.req_rs1 = '0; bus.req_rs2 = '0;
        bus.req_rs3 = '0; bus.req_use_rs3 = 1'b0; bus.rsp_ready = 1'b1;
        bus.wb_valid = 1'b0; bus.wb_wid = '0; bus.wb_rd = '0; bus.wb_tmask = '0; bus.wb_data = '0;

        v11 = fill(32'h11, 0);
        v22 = fill(32'h22, 0);
        v33 = fill(32'h33, 0);
        v31 = fill(32'h3100_0000, 1);
        v55 = fill(32'h55, 0);
        aa_exp = '0;
        aa_exp[0] = 32'hAAAA_0000;
        aa_exp[2] = 32'hAAAA_0002;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_req_ready", bus.req_ready, 1'b1);
        chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
        chk("reset_rs1_data", bus.rs1_data, '0);

        // Fresh registers read as zero, one cycle after accept.
        send(2'd0, 5'd5, 5'd6, 5'd0, 1'b0);
        wait_rsp(lat);
        chk("fresh_lat", lat, 1);
        chk("fresh_rs1", bus.rs1_data, '0);
        chk("fresh_rs2", bus.rs2_data, '0);
        chk("fresh_rs3", bus.rs3_data, '0);
        @(posedge clk); #1;

        wr(2'd1, 5'd3, 4'b0101, fill(32'hAAAA_0000, 1));
        wr(2'd0, 5'd1, 4'b1111, v11);
        wr(2'd0, 5'd2, 4'b1111, v22);
        wr(2'd0, 5'd3, 4'b1111, v33);
        wr(2'd0, 5'd0, 4'b1111, fill(32'hFF, 0));
        wr(2'd3, 5'd31, 4'b1111, v31);

        tv[0] = mk(2'd1, 5'd3,  5'd0, 5'd0,  1'b0, aa_exp, '0,     '0,  1);
        tv[1] = mk(2'd0, 5'd1,  5'd2, 5'd3,  1'b1, v11,    v22,    v33, 2);
        tv[2] = mk(2'd0, 5'd0,  5'd1, 5'd0,  1'b1, '0,     v11,    '0,  2);
        tv[3] = mk(2'd3, 5'd31, 5'd3, 5'd0,  1'b0, v31,    '0,     '0,  1);
        tv[4] = mk(2'd1, 5'd1,  5'd3, 5'd3,  1'b0, '0,     aa_exp, '0,  1);
        tv[5] = mk(2'd0, 5'd3,  5'd3, 5'd31, 1'b1, v33,    v33,    '0,  2);

        for (int k = 0; k < 6; k++) begin
            send(tv[k].wid, tv[k].rs1, tv[k].rs2, tv[k].rs3, tv[k].use3);
            if (tv[k].use3) chk($sformatf("tv%0d_rs3_ready", k), bus.req_ready, 1'b0);
            wait_rsp(lat);
            chk($sformatf("tv%0d_lat", k), lat, tv[k].lat);
            chk($sformatf("tv%0d_rs1", k), bus.rs1_data, tv[k].e1);
            chk($sformatf("tv%0d_rs2", k), bus.rs2_data, tv[k].e2);
            chk($sformatf("tv%0d_rs3", k), bus.rs3_data, tv[k].e3);
            @(posedge clk); #1;
        end

        // Backpressure: response held for 3 cycles, then handshake + new accept together.
        bus.rsp_ready = 1'b0;
        send(2'd0, 5'd1, 5'd2, 5'd0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            chk("stall_valid", bus.rsp_valid, 1'b1);
            chk("stall_ready", bus.req_ready, 1'b0);
            chk("stall_rs1", bus.rs1_data, v11);
            chk("stall_rs2", bus.rs2_data, v22);
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b1; bus.req_wid = 2'd0; bus.req_rs1 = 5'd3; bus.req_rs2 = 5'd1;
        bus.req_use_rs3 = 1'b0;
        bus.rsp_ready = 1'b1;
        #1 chk("release_ready", bus.req_ready, 1'b1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("release_valid", bus.rsp_valid, 1'b1);
        chk("release_rs1", bus.rs1_data, v33);
        chk("release_rs2", bus.rs2_data, v11);
        @(posedge clk); #1;

        // Same-cycle write and read: old value, then new value.
        bus.wb_valid = 1'b1; bus.wb_wid = 2'd2; bus.wb_rd = 5'd7;
        bus.wb_tmask = 4'b1111; bus.wb_data = v55;
        send(2'd2, 5'd7, 5'd7, 5'd0, 1'b0);
        bus.wb_valid = 1'b0;
        chk("nobypass_old", bus.rs1_data, '0);
        @(posedge clk); #1;
        send(2'd2, 5'd7, 5'd0, 5'd0, 1'b0);
        chk("nobypass_new", bus.rs1_data, v55);
        @(posedge clk); #1;
        wr(2'd2, 5'd0, 4'b1111, fill(32'h99, 0));
        send(2'd2, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("r0_zero", bus.rs1_data, '0);
        @(posedge clk); #1;

        // Asynchronous reset while the FSM is waiting for rs3.
        send(2'd0, 5'd1, 5'd2, 5'd3, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("areset_rsp_valid", bus.rsp_valid, 1'b0);
        chk("areset_idle_ready", bus.req_ready, 1'b1);
        chk("areset_rs1_data", bus.rs1_data, '0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("post_reset_ready", bus.req_ready, 1'b1);
        send(2'd0, 5'd1, 5'd2, 5'd3, 1'b1);
        wait_rsp(lat);
        chk("post_reset_lat", lat, 2);
        chk("post_reset_rs1", bus.rs1_data, '0);
        chk("post_reset_rs2", bus.rs2_data, '0);
        chk("post_reset_rs3", bus.rs3_data, '0);
        @(posedge clk); #1;

        // Random traffic over a narrow register range to force collisions.
        for (int c = 0; c < 600; c++) begin
            bus.req_valid   = ($urandom_range(0, 3) != 0);
            bus.req_wid     = 2'($urandom_range(0, 3));
            bus.req_rs1     = 5'($urandom_range(0, 7));
            bus.req_rs2     = 5'($urandom_range(0, 7));
            bus.req_rs3     = 5'($urandom_range(0, 7));
            bus.req_use_rs3 = ($urandom_range(0, 2) == 0);
            bus.rsp_ready   = ($urandom_range(0, 3) != 0);
            bus.wb_valid    = ($urandom_range(0, 1) == 1);
            bus.wb_wid      = 2'($urandom_range(0, 3));
            bus.wb_rd       = 5'($urandom_range(0, 7));
            bus.wb_tmask    = 4'($urandom_range(0, 15));
            for (int l = 0; l < NT; l++) bus.wb_data[l] = $urandom();
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        bus.wb_valid  = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("drain_outstanding", exp_q.size(), 0);
        chk("drain_valid", bus.rsp_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/vx_gpr_read_unit.md
VX_GPR_READ_UNIT -- requirements
Module: vx_gpr_read_unit

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4, number of warp register contexts.
REQ-002 SHALL have parameter NUM_THREADS, default 4, lanes per warp; each lane value is 32 bits.
REQ-003 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports req_valid/req_ready, input/output, 1 each, read-request handshake.
REQ-006 SHALL have ports req_wid (log2 NUM_WARPS), req_rs1, req_rs2, req_rs3 (5 each), req_use_rs3 (1), all inputs: read request fields.
REQ-007 SHALL have ports rsp_valid/rsp_ready, output/input, 1 each, response handshake.
REQ-008 SHALL have ports rs1_data, rs2_data, rs3_data, outputs, NUM_THREADS x 32 each: the GPR response payload.
REQ-009 SHALL have write-back inputs wb_valid (1), wb_wid (log2 NUM_WARPS), wb_rd (5), wb_tmask (NUM_THREADS), wb_data (NUM_THREADS x 32).

Function
REQ-010 SHALL hold NUM_WARPS x 32 registers of NUM_THREADS x 32 bits, with two read ports and one write port.
REQ-011 SHALL accept a request when req_valid && req_ready.
REQ-012 SHALL drive req_ready = (state == IDLE) && (!rsp_valid || rsp_ready).
REQ-013 SHALL implement an FSM with states IDLE and READ_RS3.
REQ-014 SHALL read rs1 and rs2 in the cycle a request is accepted.
REQ-015 If req_use_rs3 = 0, SHALL assert rsp_valid on the next edge with rs3_data = 0, and SHALL stay in IDLE.
REQ-016 If req_use_rs3 = 1, SHALL register rs1/rs2 data, latch wid/rs3, and go to READ_RS3.
REQ-017 In READ_RS3, SHALL read rs3 on port 0, assert rsp_valid on the next edge, and return to IDLE; latency is 2 cycles.
REQ-018 SHALL hold rsp_valid and all rs*_data stable while rsp_valid && !rsp_ready.
REQ-019 SHALL deassert rsp_valid after a handshake unless a new response is loaded on the same edge, giving back-to-back throughput of 1 per cycle without rs3.
REQ-020 SHALL always return 0 in all lanes for register index 0, regardless of writes.
REQ-021 When wb_valid, SHALL write wb_data into lane i of register (wb_wid, wb_rd) for each wb_tmask[i] = 1, leaving other lanes unchanged.
REQ-022 SHALL always accept writes; a write never stalls reads.
REQ-023 SHALL have no bypass: a read and a write to the same register in the same cycle returns the old value; the new value is visible from the next cycle.
REQ-024 SHALL ignore writes to rd = 0.
REQ-025 SHALL ignore req_* inputs while req_ready = 0.

Reset
REQ-026 On reset assertion, SHALL immediately force state = IDLE, rsp_valid = 0, rs1/rs2/rs3_data = 0, and every register to 0, regardless of clock.
REQ-027 SHALL drop any in-flight request or pending response when reset is asserted mid-operation.
REQ-028 After reset deasserts, SHALL drive req_ready = 1 on the first cycle.

Verification
REQ-029 After reset, request wid=0, rs1=5, rs2=6, use_rs3=0 -> SHALL give rsp_valid 1 cycle later with all data lanes 0.
REQ-030 Write wid=1, rd=3, tmask=4'b0101, data=0xAAAA_0000+i, then read rs1=3 -> SHALL return lanes 0,2 = 0xAAAA_0000 and 0xAAAA_0002, and lanes 1,3 = 0.
REQ-031 With use_rs3=1 and rs1=1, rs2=2, rs3=3 preloaded to 0x11, 0x22, 0x33 -> SHALL give rsp_valid 2 cycles after accept, with req_ready low in the READ_RS3 cycle.
REQ-032 Hold rsp_ready=0 for 3 cycles -> SHALL keep rsp_valid and data stable and req_ready=0; when rsp_ready rises, the handshake completes and the next request is accepted the same cycle.
REQ-033 Same-cycle write 0x55 and read of (wid 2, r7) -> SHALL return the old value 0, and the next read returns 0x55; a write to r0 still reads 0.
REQ-034 Assert reset asynchronously while in READ_RS3 -> SHALL give rsp_valid=0 before the next edge, state IDLE, and all registers 0.
